imm_decode_stage: RTL and testbench
===================================

# imm_decode_stage

Registered decode stage on the producer side of the ALU operand-B select. It accepts a fetched RV32I instruction over a valid/ready handshake and decodes it. It registers the `imme_sel` code, all five sign-extended immediates and the register addresses for the execute stage's operand mux. It adds one pipeline stage between fetch and execute, with stall and flush.

## Interface
Parameters:
- `XLEN`, 32: datapath and immediate width; only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard the held instruction and any instruction offered this cycle.
- `in_valid`  in  1  fetch presents `in_instr`/`in_pc`.
- `in_ready`  out  1  stage can accept this cycle.
- `in_instr`  in  32  raw instruction.
- `in_pc`  in  32  PC of `in_instr`.
- `out_valid`  out  1  decoded entry held.
- `out_ready`  in  1  execute consumes this cycle.
- `imme_sel`  out  3  operand-B select code.
- `i_imme`, `s_imme`, `b_imme`, `u_imme`, `uj_imme`  out  32 each  decoded immediates.
- `rs1_addr`, `rs2_addr`, `rd_addr`  out  5 each  register fields.
- `out_pc`  out  32  PC of the held entry.
- `illegal`  out  1  opcode not in the supported set.

## Operation
- `imme_sel` from `opcode = in_instr[6:0]`:
  - 0110011 → 000 (rs2).
  - 0010011, 0000011, 1100111 → 001 (I).
  - 1100011 → 010 (B).
  - 0100011 → 011 (S).
  - 0110111, 0010111 → 100 (U).
  - 1101111 → 101 (UJ).
  - Any other opcode → 000 with `illegal`=1.
- Immediates are formed for every instruction regardless of type:
  - I = sext(instr[31:20]).
  - S = sext({instr[31:25], instr[11:7]}).
  - B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U = {instr[31:12], 12'b0}.
  - UJ = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- Sign extension uses bit 31 throughout.
- Register fields: rs1 = [19:15], rs2 = [24:20], rd = [11:7]. They pass through unmodified for all formats.
- Handshake: `in_ready = !out_valid || out_ready`, combinational. A transfer occurs when `in_valid && in_ready`.
- Per-cycle priority: `rst` > `flush` > accept > drain > hold.
  - On accept, all outputs load from the decode of `in_instr`/`in_pc`, and `out_valid`←1.
  - On drain (`out_ready` with no accept), `out_valid`←0. The data registers may hold stale values.
  - On hold (`out_valid && !out_ready`), every output is unchanged whatever `in_*` does.
- Simultaneous drain and accept: the new entry replaces the old one in the same edge, giving full throughput of 1 instruction/cycle.

## Timing
- Latency: accept at edge N → decoded outputs valid after edge N, for one cycle minimum.
- Reset value of every output is 0: `out_valid`, `imme_sel`=000, all immediates, addresses, `out_pc`, `illegal`.
- `in_ready` is 1 from the first cycle after reset.
- `flush`: `out_valid` is 0 after the edge. An instruction offered in the same cycle is dropped. `in_ready` is unaffected by `flush` in that cycle.
- `rst` asserted mid-stall clears the entry at the next edge. The upstream instruction is not retained.
- `out_valid` never deasserts without `out_ready`, `flush` or `rst`.
- Data outputs are stable while `out_valid && !out_ready`.

## Structure
- Shared package `rv_decode_pkg` holds:
  - opcode constants (`OP_R`, `OP_IMM`, `OP_LOAD`, `OP_JALR`, `OP_BRANCH`, `OP_STORE`, `OP_LUI`, `OP_AUIPC`, `OP_JAL`);
  - `imme_sel` codes (`SEL_RS2`=000, `SEL_I`=001, `SEL_B`=010, `SEL_S`=011, `SEL_U`=100, `SEL_UJ`=101). The execute-stage operand mux uses these same codes.
- One combinational sub-module, `imm_gen`: instr → five immediates, `imme_sel`, `illegal`.
- The top level holds only the handshake and the pipeline register.

## Test plan
- Reset, then `in_valid`=1 with `0xFFF00093` (addi x1,x0,-1) → one cycle later:
  - `out_valid`=1, `imme_sel`=001, `i_imme`=0xFFFFFFFF;
  - `rd_addr`=1, `rs1_addr`=0, `illegal`=0.
- Back-to-back with `out_ready`=1:
  - `0x0020A423` (sw x2,8(x1)) → `imme_sel`=011, `s_imme`=8, rs1=1, rs2=2.
  - Next cycle `0xFE000EE3` (beq x0,x0,-4) → `imme_sel`=010, `b_imme`=0xFFFFFFFC.
  - `out_valid` stays 1 throughout.
- `0x123452B7` (lui x5) → `imme_sel`=100, `u_imme`=0x12345000, rd=5. Then `0x0000006F` (jal x0,0) → `imme_sel`=101, `uj_imme`=0.
- Stall: hold `out_ready`=0 for 3 cycles while offering new instructions → `in_ready`=0 and outputs unchanged. Release → the original entry drains and the pending instruction is accepted in the same edge.
- `0x00000000` → `illegal`=1, `imme_sel`=000.
- `flush` together with `in_valid` → `out_valid`=0 next cycle.
- `rst` during a stall → all outputs 0 next cycle.

Source files
------------

// File: rtl/rv_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_decode_pkg
// Description : Shared RV32I decode definitions: base opcodes and the
//               operand-B select codes understood by the execute-stage mux.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_decode_pkg;

    // RV32I base opcodes (instr[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Operand-B select codes; the execute-stage mux decodes these same values.
    localparam logic [2:0] SEL_RS2 = 3'b000;
    localparam logic [2:0] SEL_I   = 3'b001;
    localparam logic [2:0] SEL_B   = 3'b010;
    localparam logic [2:0] SEL_S   = 3'b011;
    localparam logic [2:0] SEL_U   = 3'b100;
    localparam logic [2:0] SEL_UJ  = 3'b101;

endpackage : rv_decode_pkg
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen
// Description : Combinational RV32I immediate generator. Forms all five
//               immediate formats for every instruction and classifies the
//               opcode into an operand-B select code.
// Ports       : instr    - raw instruction
//               i_imme, s_imme, b_imme, u_imme, uj_imme - immediates
//               imme_sel - operand-B select code
//               illegal  - opcode outside the supported set
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
    import rv_decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] i_imme,
    output logic [31:0] s_imme,
    output logic [31:0] b_imme,
    output logic [31:0] u_imme,
    output logic [31:0] uj_imme,
    output logic [2:0]  imme_sel,
    output logic        illegal
);

    logic       w_sign;
    logic [6:0] w_opcode;

    assign w_sign   = instr[31];
    assign w_opcode = instr[6:0];

    // Immediates are built unconditionally; the select code decides which
    // one execute actually uses.
    assign i_imme  = {{20{w_sign}}, instr[31:20]};
    assign s_imme  = {{20{w_sign}}, instr[31:25], instr[11:7]};
    assign b_imme  = {{19{w_sign}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign u_imme  = {instr[31:12], 12'b0};
    assign uj_imme = {{11{w_sign}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        imme_sel = SEL_RS2;
        illegal  = 1'b0;
        case (w_opcode)
            OP_R:                      imme_sel = SEL_RS2;
            OP_IMM, OP_LOAD, OP_JALR:  imme_sel = SEL_I;
            OP_BRANCH:                 imme_sel = SEL_B;
            OP_STORE:                  imme_sel = SEL_S;
            OP_LUI, OP_AUIPC:          imme_sel = SEL_U;
            OP_JAL:                    imme_sel = SEL_UJ;
            default: begin
                imme_sel = SEL_RS2;
                illegal  = 1'b1;
            end
        endcase
    end

endmodule : imm_gen
`default_nettype wire

// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_stage
// Description : One-entry registered decode stage between fetch and execute.
//               Accepts an instruction over valid/ready, decodes immediates,
//               select code and register fields, and holds them for execute.
//               Supports stall (out_ready low) and flush.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               flush                 - drop held and offered instruction
//               in_valid/in_ready     - fetch-side handshake
//               in_instr, in_pc       - instruction and its PC
//               out_valid/out_ready   - execute-side handshake
//               imme_sel, *_imme      - decoded select code and immediates
//               rs1/rs2/rd_addr       - register fields
//               out_pc, illegal       - held PC, unsupported opcode flag
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      imme_sel,
    output logic [XLEN-1:0] i_imme,
    output logic [XLEN-1:0] s_imme,
    output logic [XLEN-1:0] b_imme,
    output logic [XLEN-1:0] u_imme,
    output logic [XLEN-1:0] uj_imme,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] out_pc,
    output logic            illegal
);

    logic [31:0] w_i_imme;
    logic [31:0] w_s_imme;
    logic [31:0] w_b_imme;
    logic [31:0] w_u_imme;
    logic [31:0] w_uj_imme;
    logic [2:0]  w_imme_sel;
    logic        w_illegal;
    logic        w_accept;

    logic            r_out_valid;
    logic [2:0]      r_imme_sel;
    logic [XLEN-1:0] r_i_imme;
    logic [XLEN-1:0] r_s_imme;
    logic [XLEN-1:0] r_b_imme;
    logic [XLEN-1:0] r_u_imme;
    logic [XLEN-1:0] r_uj_imme;
    logic [4:0]      r_rs1_addr;
    logic [4:0]      r_rs2_addr;
    logic [4:0]      r_rd_addr;
    logic [XLEN-1:0] r_out_pc;
    logic            r_illegal;

    imm_gen u_imm_gen (
        .instr    (in_instr),
        .i_imme   (w_i_imme),
        .s_imme   (w_s_imme),
        .b_imme   (w_b_imme),
        .u_imme   (w_u_imme),
        .uj_imme  (w_uj_imme),
        .imme_sel (w_imme_sel),
        .illegal  (w_illegal)
    );

    // Ready whenever the slot is empty or being emptied this cycle, so a
    // drain and an accept can share one edge. Flush deliberately does not
    // gate ready; it only suppresses the load below.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_imme_sel  <= SEL_RS2;
            r_i_imme    <= '0;
            r_s_imme    <= '0;
            r_b_imme    <= '0;
            r_u_imme    <= '0;
            r_uj_imme   <= '0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_rd_addr   <= '0;
            r_out_pc    <= '0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_imme_sel  <= w_imme_sel;
            r_i_imme    <= w_i_imme;
            r_s_imme    <= w_s_imme;
            r_b_imme    <= w_b_imme;
            r_u_imme    <= w_u_imme;
            r_uj_imme   <= w_uj_imme;
            r_rs1_addr  <= in_instr[19:15];
            r_rs2_addr  <= in_instr[24:20];
            r_rd_addr   <= in_instr[11:7];
            r_out_pc    <= in_pc;
            r_illegal   <= w_illegal;
        end else if (out_ready) begin
            // Data registers keep stale contents; only valid drops.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign imme_sel  = r_imme_sel;
    assign i_imme    = r_i_imme;
    assign s_imme    = r_s_imme;
    assign b_imme    = r_b_imme;
    assign u_imme    = r_u_imme;
    assign uj_imme   = r_uj_imme;
    assign rs1_addr  = r_rs1_addr;
    assign rs2_addr  = r_rs2_addr;
    assign rd_addr   = r_rd_addr;
    assign out_pc    = r_out_pc;
    assign illegal   = r_illegal;

endmodule : imm_decode_stage
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_decode_stage
// Description : Directed self-checking bench for imm_decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_decode_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  imme_sel;
    logic [31:0] i_imme;
    logic [31:0] s_imme;
    logic [31:0] b_imme;
    logic [31:0] u_imme;
    logic [31:0] uj_imme;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] out_pc;
    logic        illegal;

    int pass_cnt;
    int total_cnt;

    imm_decode_stage #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imme_sel  (imme_sel),
        .i_imme    (i_imme),
        .s_imme    (s_imme),
        .b_imme    (b_imme),
        .u_imme    (u_imme),
        .uj_imme   (uj_imme),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rd_addr   (rd_addr),
        .out_pc    (out_pc),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc = 32'h0;
        tick(); tick();
        total_cnt++;
        if ({out_valid, imme_sel, i_imme, s_imme, b_imme, u_imme, uj_imme,
             rs1_addr, rs2_addr, rd_addr, out_pc, illegal} !== '0)
            $display("FAIL reset_outputs: some output nonzero sel=%b i=%h pc=%h v=%b", imme_sel, i_imme, out_pc, out_valid);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_addi();
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h0000_0100; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL addi_valid: got %b expected 1", out_valid); else pass_cnt++;
        total_cnt++;
        if (imme_sel !== 3'b001) $display("FAIL addi_sel: got %b expected 001", imme_sel); else pass_cnt++;
        total_cnt++;
        if (i_imme !== 32'hFFFFFFFF) $display("FAIL addi_i_imme: got %h expected ffffffff", i_imme); else pass_cnt++;
        total_cnt++;
        if (rd_addr !== 5'd1 || rs1_addr !== 5'd0)
            $display("FAIL addi_regs: got rd=%0d rs1=%0d expected rd=1 rs1=0", rd_addr, rs1_addr);
        else pass_cnt++;
        total_cnt++;
        if (illegal !== 1'b0 || out_pc !== 32'h100)
            $display("FAIL addi_ill_pc: got ill=%b pc=%h expected ill=0 pc=00000100", illegal, out_pc);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL addi_drain: got %b expected 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h0020A423; in_pc = 32'h200;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || imme_sel !== 3'b011 || s_imme !== 32'd8)
            $display("FAIL sw_decode: got v=%b sel=%b s=%h expected v=1 sel=011 s=00000008", out_valid, imme_sel, s_imme);
        else pass_cnt++;
        total_cnt++;
        if (rs1_addr !== 5'd1 || rs2_addr !== 5'd2 || i_imme !== 32'd2)
            $display("FAIL sw_fields: got rs1=%0d rs2=%0d i=%h expected rs1=1 rs2=2 i=00000002", rs1_addr, rs2_addr, i_imme);
        else pass_cnt++;
        in_instr = 32'hFE000EE3; in_pc = 32'h204;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || imme_sel !== 3'b010 || b_imme !== 32'hFFFFFFFC || out_pc !== 32'h204)
            $display("FAIL beq_decode: got v=%b sel=%b b=%h pc=%h expected v=1 sel=010 b=fffffffc pc=00000204",
                     out_valid, imme_sel, b_imme, out_pc);
        else pass_cnt++;
        in_instr = 32'h123452B7; in_pc = 32'h208;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || imme_sel !== 3'b100 || u_imme !== 32'h12345000 || rd_addr !== 5'd5)
            $display("FAIL lui_decode: got v=%b sel=%b u=%h rd=%0d expected v=1 sel=100 u=12345000 rd=5",
                     out_valid, imme_sel, u_imme, rd_addr);
        else pass_cnt++;
        in_instr = 32'h0000006F; in_pc = 32'h20C;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || imme_sel !== 3'b101 || uj_imme !== 32'h0)
            $display("FAIL jal_decode: got v=%b sel=%b uj=%h expected v=1 sel=101 uj=00000000", out_valid, imme_sel, uj_imme);
        else pass_cnt++;
        in_instr = 32'h00000000; in_pc = 32'h210;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || illegal !== 1'b1 || imme_sel !== 3'b000)
            $display("FAIL illegal_decode: got v=%b ill=%b sel=%b expected v=1 ill=1 sel=000", out_valid, illegal, imme_sel);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h300;
        tick();
        // Offer lui while stalled; it must not disturb the held addi.
        in_instr = 32'h123452B7; in_pc = 32'h304;
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %b expected 0", k, in_ready);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (out_valid !== 1'b1 || imme_sel !== 3'b001 || i_imme !== 32'hFFFFFFFF ||
                rd_addr !== 5'd1 || out_pc !== 32'h300)
                $display("FAIL stall_hold[%0d]: got v=%b sel=%b i=%h rd=%0d pc=%h expected v=1 sel=001 i=ffffffff rd=1 pc=00000300",
                         k, out_valid, imme_sel, i_imme, rd_addr, out_pc);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || imme_sel !== 3'b100 || u_imme !== 32'h12345000 || out_pc !== 32'h304)
            $display("FAIL release_accept: got v=%b sel=%b u=%h pc=%h expected v=1 sel=100 u=12345000 pc=00000304",
                     out_valid, imme_sel, u_imme, out_pc);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0020A423; in_pc = 32'h400;
        tick();
        flush = 1'b1; in_instr = 32'h0000006F; in_pc = 32'h404;
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b expected 0", in_ready); else pass_cnt++;
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL flush_in_ready_open: got %b expected 1", in_ready); else pass_cnt++;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", out_valid); else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL flush_dropped: got %b expected 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_reset_in_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFE000EE3; in_pc = 32'h500;
        tick();
        in_instr = 32'h123452B7; in_pc = 32'h504;
        rst = 1'b1;
        tick();
        total_cnt++;
        if ({out_valid, imme_sel, i_imme, s_imme, b_imme, u_imme, uj_imme,
             rs1_addr, rs2_addr, rd_addr, out_pc, illegal} !== '0)
            $display("FAIL rst_stall_outputs: got v=%b sel=%b b=%h pc=%h expected all zero", out_valid, imme_sel, b_imme, out_pc);
        else pass_cnt++;
        rst = 1'b0; in_valid = 1'b0;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0 || u_imme !== 32'h0)
            $display("FAIL rst_stall_not_retained: got v=%b u=%h expected v=0 u=00000000", out_valid, u_imme);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_addi();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_in_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_imm_decode_stage
`default_nettype wire
